// File: rtl/vga_frame_grabber_if.sv
// Avalon-MM slave bus of the VGA frame grabber.
interface vga_frame_grabber_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, read, write, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, read, write, address, writedata,
    output readdata
  );
endinterface

// File: rtl/vga_frame_grabber.sv
// Captures one decimated VGA frame into a FIFO and serves it over Avalon-MM.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for the next VSYNC falling edge
// CAPTURE | counting active pixels, pushing the decimated ones
// DONE    | frame finished (complete or cut short); FIFO still readable
module vga_frame_grabber #(
  parameter int FIFO_DEPTH = 64,
  parameter int DECIM_LOG2 = 2,
  parameter int ACTIVE_W   = 640,
  parameter int ACTIVE_H   = 480
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_grabber_if.slave  bus,
  input  logic [7:0]          VGA_R,
  input  logic [7:0]          VGA_G,
  input  logic [7:0]          VGA_B,
  input  logic                VGA_BLANK_n,
  input  logic                HSYNC,
  input  logic                VSYNC,
  output logic                irq
);

  localparam int XW    = $clog2(ACTIVE_W);
  localparam int YW    = $clog2(ACTIVE_H);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = AW + 1;
  localparam int DMASK = (1 << DECIM_LOG2) - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill;
  logic          vs_q;
  logic          overflow, frame_done, short_frame;

  logic empty, full, reg_wr, arm, abort, clr, vs_fall, pop;
  logic pix_valid, keep, push_req, push, ovf_set, last_pix, short_set;
  logic unused_bits;

  assign empty   = (fill == '0);
  assign full    = (fill == FW'(FIFO_DEPTH));
  assign reg_wr  = bus.chipselect && bus.write && (bus.address == 8'd2);
  assign arm     = reg_wr && bus.writedata[0];
  assign abort   = reg_wr && bus.writedata[1];
  assign clr     = reg_wr && bus.writedata[2];
  assign vs_fall = vs_q && !VSYNC;
  assign pop     = bus.chipselect && bus.read && (bus.address == 8'd0) && !empty;

  // A VSYNC edge inside a capture ends the frame; that cycle carries no pixel.
  assign pix_valid = (state == S_CAPTURE) && VGA_BLANK_n && !vs_fall && !abort;
  assign keep      = ((x & XW'(DMASK)) == '0) && ((y & YW'(DMASK)) == '0);
  assign push_req  = pix_valid && keep;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign last_pix  = pix_valid && (x == XW'(ACTIVE_W - 1)) && (y == YW'(ACTIVE_H - 1));
  assign short_set = (state == S_CAPTURE) && vs_fall && !abort;

  assign irq = frame_done;

  assign unused_bits = ^{bus.writedata[31:3], HSYNC};

  // Register copy of VSYNC for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vs_q <= 1'b1;
    else        vs_q <= VSYNC;
  end

  // Capture state machine and pixel position counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        S_IDLE:  if (arm) state <= S_ARMED;
        S_ARMED: if (vs_fall) begin
          state <= S_CAPTURE;
          x     <= '0;
          y     <= '0;
        end
        S_CAPTURE: begin
          if (vs_fall) begin
            state <= S_DONE;
          end else if (VGA_BLANK_n) begin
            if (last_pix) state <= S_DONE;
            if (x == XW'(ACTIVE_W - 1)) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: if (arm) state <= S_ARMED;
      endcase
    end
  end

  // FIFO pointers and fill level; abort flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Pixel storage; contents need no reset since fill gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {VGA_R, VGA_G, VGA_B};
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      if (ovf_set)                   overflow    <= 1'b1;
      else if (clr)                  overflow    <= 1'b0;
      if (last_pix || short_set)     frame_done  <= 1'b1;
      else if (clr)                  frame_done  <= 1'b0;
      if (short_set)                 short_frame <= 1'b1;
      else if (clr)                  short_frame <= 1'b0;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect && bus.read) begin
      case (bus.address)
        8'd0: if (!empty) bus.readdata = {mem[rd_ptr], 8'h00};
        8'd1: bus.readdata = {9'd0, short_frame, state, frame_done, overflow,
                              full, empty, 16'(fill)};
        default: bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_grabber.sv
// Self-checking bench for vga_frame_grabber on a reduced 80x60 raster.
module tb_vga_frame_grabber;

  localparam int W     = 80;
  localparam int H     = 60;
  localparam int D     = 2;
  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_blank_n, hsync, vsync, irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  vga_frame_grabber_if bus();

  vga_frame_grabber #(
    .FIFO_DEPTH(DEPTH), .DECIM_LOG2(D), .ACTIVE_W(W), .ACTIVE_H(H)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_BLANK_n(vga_blank_n),
    .HSYNC(hsync), .VSYNC(vsync), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: pixel i of a frame is at (i%W, i/W); kept if both on the grid.
  function automatic bit kept(input int i);
    int px, py;
    px = i % W;
    py = i / W;
    return ((px % (1 << D)) == 0) && ((py % (1 << D)) == 0);
  endfunction

  function automatic logic [31:0] pix_word(input int i);
    int px, py;
    px = i % W;
    py = i / W;
    return {px[7:0], py[7:0], 8'h5A, 8'h00};
  endfunction

  task automatic build_expected(input int npix);
    exp_q.delete();
    for (int i = 0; i < npix; i++) if (kept(i)) exp_q.push_back(pix_word(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic set_pixel(input int i);
    int px, py;
    px = i % W;
    py = i / W;
    vga_blank_n = 1'b1;
    vga_r = px[7:0];
    vga_g = py[7:0];
    vga_b = 8'h5A;
  endtask

  task automatic pixel(input int i);
    set_pixel(i);
    tick();
  endtask

  task automatic vs_pulse();
    vsync = 1'b0; tick();
    vsync = 1'b1; tick();
  endtask

  task automatic drive_vga(input int npix, input bit lead, input bit trail);
    if (lead) vs_pulse();
    for (int i = 0; i < npix; i++) begin
      if (i % W == 0) begin
        vga_blank_n = 1'b0; hsync = 1'b0; tick(); tick(); hsync = 1'b1;
      end
      if ($urandom_range(3, 0) == 0) begin
        vga_blank_n = 1'b0; tick();
      end
      pixel(i);
    end
    vga_blank_n = 1'b0;
    if (trail) vs_pulse();
  endtask

  task automatic drain(input int n, input int budget, input string tag);
    int got, cyc;
    logic [31:0] d;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      if ($urandom_range(1, 0) == 1) begin
        bus_read(8'd0, d);
        if (d != 32'd0) begin
          checks++;
          if (d !== exp_q[got]) begin
            errors++;
            $display("FAIL %s word %0d got %h exp %h", tag, got, d, exp_q[got]);
          end
          got++;
        end
      end else begin
        tick();
      end
      cyc++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s word count got %0d exp %0d", tag, got, n);
    end
  endtask

  task automatic check_status(input logic [31:0] expv, input string tag);
    logic [31:0] s;
    bus_read(8'd1, s);
    checks++;
    if (s !== expv) begin
      errors++;
      $display("FAIL %s status got %h exp %h", tag, s, expv);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = 8'd0; bus.writedata = 32'd0;
    vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
    vga_blank_n = 1'b0; hsync = 1'b1; vsync = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_status(32'h0001_0000, "reset");
    bus_read(8'd0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_head got %h exp 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    bus_write(8'd9, $urandom());
    bus_read(8'd7, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h exp 0", d); end
    check_status(32'h0001_0000, "unmapped_write");
  endtask

  task automatic test_full_frame();
    logic [31:0] d;
    build_expected(W * H);
    bus_write(8'd2, 32'd1);
    check_status(32'h0011_0000, "armed");
    fork
      drive_vga(W * H, 1'b1, 1'b0);
      drain(exp_q.size(), 20000, "full_frame");
    join
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL frame_irq got %b exp 1", irq); end
    check_status(32'h0039_0000, "frame_done");
    bus_read(8'd0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL frame_extra got %h exp 0", d); end
    bus_write(8'd2, 32'd4);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq got %b exp 0", irq); end
    check_status(32'h0031_0000, "frame_clear");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    build_expected(W * H);
    bus_write(8'd2, 32'd1);
    drive_vga(W * H, 1'b1, 1'b0);
    check_status(32'h003E_0040, "overflow_full");
    for (int k = 0; k < DEPTH; k++) begin
      bus_read(8'd0, d);
      checks++;
      if (d !== exp_q[k]) begin
        errors++;
        $display("FAIL overflow_pop %0d got %h exp %h", k, d, exp_q[k]);
      end
    end
    check_status(32'h003D_0000, "overflow_drained");
    bus_write(8'd2, 32'd4);
    check_status(32'h0031_0000, "overflow_clear");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL overflow_irq got %b exp 0", irq); end
  endtask

  task automatic test_short_frame();
    build_expected(20 * W);
    bus_write(8'd2, 32'd1);
    fork
      drive_vga(20 * W, 1'b1, 1'b1);
      drain(exp_q.size(), 20000, "short_frame");
    join
    check_status(32'h0079_0000, "short_frame");
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL short_irq got %b exp 1", irq); end
    bus_write(8'd2, 32'd4);
    check_status(32'h0031_0000, "short_clear");
  endtask

  task automatic test_abort();
    int n, nk;
    n = $urandom_range(3 * W, 1);
    nk = 0;
    for (int i = 0; i < n; i++) if (kept(i)) nk++;
    bus_write(8'd2, 32'd1);
    drive_vga(n, 1'b1, 1'b0);
    check_status(32'h0020_0000 | 32'(nk), "abort_before");
    bus_write(8'd2, 32'd2);
    check_status(32'h0001_0000, "abort_after");
    drive_vga(4 * W, 1'b1, 1'b0);
    check_status(32'h0001_0000, "abort_no_rearm");
    bus_write(8'd2, 32'd1);
    check_status(32'h0011_0000, "rearm");
    bus_write(8'd2, 32'd3);
    check_status(32'h0001_0000, "abort_beats_arm");
  endtask

  task automatic test_push_read_edge();
    logic [31:0] d;
    int i, k;
    bus_write(8'd2, 32'd1);
    vs_pulse();
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 8'd0;
    set_pixel(0);
    @(negedge clk);
    d = bus.readdata;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0; vga_blank_n = 1'b0;
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL empty_push_read got %h exp 0", d); end
    check_status(32'h0020_0001, "empty_push_fill");
    i = 1;
    k = 1;
    while (k < DEPTH) begin
      pixel(i);
      if (kept(i)) k++;
      i++;
    end
    while (!kept(i)) begin pixel(i); i++; end
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 8'd0;
    set_pixel(i);
    @(negedge clk);
    d = bus.readdata;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0; vga_blank_n = 1'b0;
    i++;
    checks++;
    if (d !== pix_word(0)) begin
      errors++;
      $display("FAIL full_push_read got %h exp %h", d, pix_word(0));
    end
    check_status(32'h0022_0040, "full_push_pop");
    while (!kept(i)) begin pixel(i); i++; end
    pixel(i);
    vga_blank_n = 1'b0;
    check_status(32'h0026_0040, "full_push_drop");
    bus_write(8'd2, 32'd6);
    check_status(32'h0001_0000, "edge_cleanup");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(8'd2, 32'd1);
    drive_vga(100, 1'b1, 1'b0);
    check_status(32'h0020_0014, "mid_before");
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 8'd1;
    reset = 1'b0;
    #2;
    d = bus.readdata;
    checks++;
    if (d !== 32'h0001_0000) begin errors++; $display("FAIL async_reset got %h exp 00010000", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq got %b exp 0", irq); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    check_status(32'h0001_0000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_short_frame();
    test_abort();
    test_push_read_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
